// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader: memory geometry,
// the load-terminating halt instruction and the loader state encoding.
package imem_stream_loader_pkg;

    localparam int IMEM_BYTES = 256;
    localparam int ADDR_W     = $clog2(IMEM_BYTES);
    localparam int MAX_WORDS  = IMEM_BYTES / 4;
    localparam int COUNT_W    = $clog2(MAX_WORDS) + 1;

    // Must match the halt detect in toy_processor.
    localparam logic [31:0] HALT_WORD = 32'h0000_003f;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_t;

    // Big-endian byte select: index 0 is bits [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_stream_loader_serializer.sv
// Holds one accepted instruction word and presents it as four registered
// big-endian bytes, one per beat, flagging the final beat.
module imem_stream_loader_serializer
    import imem_stream_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] in_word,
    output logic [31:0] word_buf,
    output logic [7:0]  byte_data,
    output logic        last_beat
);

    logic [1:0] byte_idx;

    assign last_beat = (byte_idx == 2'd3);

    // NOTE: word_buf is reset too; it is tiny, and a known value keeps the halt compare clean after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_buf  <= '0;
            byte_idx  <= '0;
            byte_data <= '0;
        end else if (load) begin
            word_buf  <= in_word;
            byte_idx  <= '0;
            byte_data <= word_byte(in_word, 2'd0);
        end else if (advance) begin
            byte_idx  <= byte_idx + 2'd1;
            byte_data <= word_byte(word_buf, byte_idx + 2'd1);
        end else if (clear) begin
            byte_idx  <= '0;
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory while
// holding the processor in reset, then releases it once the program is loaded.
module imem_stream_loader
    import imem_stream_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_word,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               halt_seen,
    output logic [COUNT_W-1:0] word_count
);

    loader_state_t state;
    loader_state_t next_state;

    logic [31:0] word_buf;
    logic        beat_last;
    logic        accept;
    logic        in_write;
    logic        word_end;
    logic        is_halt;
    logic        last_slot;
    logic        clear;

    logic               in_ready_d;
    logic               mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic               cpu_reset_d;
    logic               done_d;
    logic               halt_seen_d;
    logic [COUNT_W-1:0] word_count_d;

    assign accept    = (state == ST_ACCEPT) && in_valid && in_ready;
    assign in_write  = (state == ST_WRITE);
    assign word_end  = in_write && beat_last;
    assign is_halt   = (word_buf == HALT_WORD);
    assign last_slot = (word_count == COUNT_W'(MAX_WORDS - 1));
    // A new load may only begin from rest; start mid-load is ignored.
    assign clear     = start && ((state == ST_IDLE) || (state == ST_DONE));

    imem_stream_loader_serializer u_serializer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (accept),
        .advance   (in_write && !beat_last),
        .in_word   (in_word),
        .word_buf  (word_buf),
        .byte_data (mem_wdata),
        .last_beat (beat_last)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (accept) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (beat_last) begin
                    if (is_halt || last_slot) next_state = ST_DONE;
                    else                      next_state = ST_ACCEPT;
                end
            end
            ST_DONE: begin
                if (start) next_state = ST_ACCEPT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output values for the next cycle, decoded from the next state so they can be registered.
    always_comb begin
        in_ready_d   = (next_state == ST_ACCEPT);
        mem_we_d     = (next_state == ST_WRITE);
        done_d       = (next_state == ST_DONE);
        cpu_reset_d  = (next_state != ST_DONE);
        mem_addr_d   = mem_addr;
        word_count_d = word_count;
        halt_seen_d  = halt_seen;

        if (accept) begin
            mem_addr_d = ADDR_W'({word_count, 2'b00});
        end else if (in_write && !beat_last) begin
            mem_addr_d = mem_addr + ADDR_W'(1);
        end

        if (clear) begin
            word_count_d = '0;
            halt_seen_d  = 1'b0;
        end else if (word_end) begin
            word_count_d = word_count + COUNT_W'(1);
            halt_seen_d  = is_halt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            halt_seen  <= 1'b0;
            word_count <= '0;
        end else begin
            in_ready   <= in_ready_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            cpu_reset  <= cpu_reset_d;
            done       <= done_d;
            halt_seen  <= halt_seen_d;
            word_count <= word_count_d;
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: randomized word streams compared
// against a byte-level model of what a big-endian program load must write.
module tb_imem_stream_loader;

    localparam logic [31:0] HALT = 32'h0000_003f;
    localparam int          MAXW = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        halt_seen;
    logic [6:0]  word_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] wr_q[$];
    logic [31:0] acc_q[$];
    int          acc_cyc_q[$];
    logic [31:0] src_q[$];
    logic [31:0] model_in[$];
    logic [15:0] exp_q[$];
    int          exp_wc;
    bit          exp_halt;

    imem_stream_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .halt_seen  (halt_seen),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed memory writes and handshakes, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
        if (in_valid && in_ready) begin
            acc_q.push_back(in_word);
            acc_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        acc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    // Reference: a program of words lands big-endian at consecutive byte addresses,
    // stopping after the halt word or after the memory is full.
    task automatic model_load();
        int n;
        n = 0;
        exp_q.delete();
        exp_halt = 1'b0;
        foreach (model_in[k]) begin
            if (n == MAXW || exp_halt) break;
            for (int j = 0; j < 4; j++)
                exp_q.push_back({8'(4 * n + j), 8'(model_in[k] >> (24 - 8 * j))});
            n++;
            if (model_in[k] == HALT) exp_halt = 1'b1;
        end
        exp_wc = n;
    endtask

    // Drives src_q over valid/ready until done or budget; garbage is shown on in_word while not ready.
    task automatic feed(input int idle_pct, input bit hold, input bit start_noise,
                        input int budget, output bit timed_out);
        int n;
        n = 0;
        while (!done && n < budget) begin
            if (in_ready && src_q.size() > 0 && $urandom_range(99) >= idle_pct) begin
                in_valid = 1'b1;
                in_word  = src_q.pop_front();
            end else begin
                in_valid = in_ready ? 1'b0 : (hold ? 1'b1 : 1'($urandom_range(1)));
                in_word  = $urandom;
            end
            start = (start_noise && (mem_we || in_ready)) ? 1'($urandom_range(1)) : 1'b0;
            step();
            n++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        timed_out = !done;
    endtask

    task automatic test_reset();
        logic [31:0] got[8];
        logic [31:0] want[8];
        string       nm[8];
        reset = 1'b1; start = 1'b1; in_valid = 1'b0; in_word = '0;
        step(); step();
        got  = '{in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, halt_seen, word_count};
        want = '{0, 0, 0, 0, 1, 0, 0, 0};
        nm   = '{"in_ready", "mem_we", "mem_addr", "mem_wdata", "cpu_reset", "done", "halt_seen", "word_count"};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL reset_%s: got %0h expected %0h", nm[i], got[i], want[i]);
            end
        end
        reset = 1'b0; start = 1'b0; in_valid = 1'b1; in_word = HALT;
        repeat (4) step();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, mem_we, cpu_reset, done} !== 4'b0010 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL idle_ignores_valid: got rdy/we/rst/done=%b writes=%0d expected 0010 writes=0",
                     {in_ready, mem_we, cpu_reset, done}, wr_q.size());
        end
    endtask

    task automatic test_halt_load();
        bit to;
        clear_logs();
        src_q    = '{32'h2001_0005, 32'h0022_0820, 32'h0000_003f};
        model_in = src_q;
        model_load();
        pulse_start();
        feed(0, 1'b0, 1'b0, 100, to);
        checks++;
        if (to) begin errors++; $display("FAIL halt_load_timeout: done=%b expected 1", done); end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL halt_load_nwrites: got %0d expected %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL halt_load_write%0d: got addr/data %h expected %h", i, wr_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({word_count, halt_seen, done, cpu_reset} !== {7'd3, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL halt_load_status: got wc=%0d halt=%b done=%b cpu_reset=%b expected 3 1 1 0",
                     word_count, halt_seen, done, cpu_reset);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        clear_logs();
        src_q.delete();
        for (int i = 0; i < 6; i++) src_q.push_back(rand_word());
        src_q.push_back(HALT);
        model_in = src_q;
        model_load();
        pulse_start();
        feed(0, 1'b1, 1'b0, 200, to);
        checks++;
        if (to) begin errors++; $display("FAIL b2b_timeout: done=%b expected 1", done); end
        checks++;
        if (acc_q.size() != model_in.size()) begin
            errors++;
            $display("FAIL b2b_naccepted: got %0d expected %0d", acc_q.size(), model_in.size());
        end
        for (int i = 0; i < acc_q.size() && i < model_in.size(); i++) begin
            checks++;
            if (acc_q[i] !== model_in[i]) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h expected %h", i, acc_q[i], model_in[i]);
            end
        end
        for (int i = 1; i < acc_cyc_q.size(); i++) begin
            checks++;
            if (acc_cyc_q[i] - acc_cyc_q[i-1] != 5) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles expected 5", i, acc_cyc_q[i] - acc_cyc_q[i-1]);
            end
        end
        checks++;
        if (wr_q != exp_q) begin
            errors++;
            $display("FAIL b2b_writes: got %0d writes expected %0d matching model", wr_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random_load(input bit start_noise);
        bit to;
        int k;
        for (int iter = 0; iter < 3; iter++) begin
            clear_logs();
            src_q.delete();
            k = $urandom_range(4, 12);
            for (int i = 0; i < k; i++) src_q.push_back(rand_word());
            src_q.push_back(HALT);
            for (int i = 0; i < 3; i++) src_q.push_back(rand_word());
            model_in = src_q;
            model_load();
            pulse_start();
            feed(30, 1'b0, start_noise, 400, to);
            checks++;
            if (to) begin errors++; $display("FAIL rand%0d_timeout: done=%b expected 1", iter, done); end
            checks++;
            if (wr_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_nwrites: got %0d expected %0d", iter, wr_q.size(), exp_q.size());
            end
            for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: got %h expected %h", iter, i, wr_q[i], exp_q[i]);
                end
            end
            checks++;
            if (word_count !== 7'(exp_wc) || halt_seen !== exp_halt || acc_q.size() != k + 1) begin
                errors++;
                $display("FAIL rand%0d_status: got wc=%0d halt=%b acc=%0d expected %0d %b %0d",
                         iter, word_count, halt_seen, acc_q.size(), exp_wc, exp_halt, k + 1);
            end
        end
        src_q.delete();
    endtask

    task automatic test_full_load();
        bit to;
        int nacc;
        int nwr;
        clear_logs();
        src_q.delete();
        for (int i = 0; i < MAXW; i++) src_q.push_back(32'h1000_0000 + 32'(i));
        model_in = src_q;
        model_load();
        pulse_start();
        feed(0, 1'b0, 1'b0, 600, to);
        checks++;
        if (to) begin errors++; $display("FAIL full_timeout: done=%b expected 1", done); end
        checks++;
        if (wr_q != exp_q) begin
            errors++;
            $display("FAIL full_writes: got %0d writes expected %0d matching model", wr_q.size(), exp_q.size());
        end
        checks++;
        if (wr_q.size() == 0 || wr_q[wr_q.size()-1] !== 16'hff3f) begin
            errors++;
            $display("FAIL full_last_write: got %h expected ff3f",
                     (wr_q.size() == 0) ? 16'h0 : wr_q[wr_q.size()-1]);
        end
        checks++;
        if ({word_count, halt_seen, done, cpu_reset} !== {7'd64, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL full_status: got wc=%0d halt=%b done=%b cpu_reset=%b expected 64 0 1 0",
                     word_count, halt_seen, done, cpu_reset);
        end
        nacc = acc_q.size();
        nwr  = wr_q.size();
        in_valid = 1'b1;
        in_word  = 32'h1000_0040;
        repeat (10) step();
        in_valid = 1'b0;
        checks++;
        if (acc_q.size() != nacc || wr_q.size() != nwr || word_count !== 7'd64 || done !== 1'b1) begin
            errors++;
            $display("FAIL extra_word_ignored: got acc=%0d wr=%0d wc=%0d done=%b expected %0d %0d 64 1",
                     acc_q.size(), wr_q.size(), word_count, done, nacc, nwr);
        end
    endtask

    task automatic test_restart();
        bit to;
        clear_logs();
        pulse_start();
        checks++;
        if ({cpu_reset, done, halt_seen, in_ready, word_count} !== {4'b1001, 7'd0}) begin
            errors++;
            $display("FAIL restart_status: got rst=%b done=%b halt=%b rdy=%b wc=%0d expected 1 0 0 1 0",
                     cpu_reset, done, halt_seen, in_ready, word_count);
        end
        src_q    = '{rand_word(), HALT};
        model_in = src_q;
        model_load();
        feed(20, 1'b0, 1'b0, 100, to);
        checks++;
        if (to || wr_q != exp_q || word_count !== 7'd2) begin
            errors++;
            $display("FAIL restart_reload: got writes=%0d wc=%0d timeout=%b expected writes=8 wc=2 timeout=0",
                     wr_q.size(), word_count, to);
        end
    endtask

    task automatic test_reset_mid_write();
        bit hit;
        hit = 1'b0;
        clear_logs();
        src_q    = '{rand_word(), rand_word(), rand_word()};
        model_in = src_q;
        model_load();
        pulse_start();
        for (int n = 0; n < 100 && !hit; n++) begin
            in_valid = in_ready && src_q.size() > 0;
            if (in_valid) in_word = src_q.pop_front();
            step();
            hit = mem_we && mem_addr == 8'd6;
        end
        in_valid = 1'b0;
        checks++;
        if (!hit) begin errors++; $display("FAIL midreset_reach_beat2: got no write to addr 6 expected one"); end
        reset = 1'b1;
        step();
        checks++;
        if ({mem_we, cpu_reset, in_ready, done, word_count} !== {4'b0100, 7'd0}) begin
            errors++;
            $display("FAIL midreset_status: got we=%b rst=%b rdy=%b done=%b wc=%0d expected 0 1 0 0 0",
                     mem_we, cpu_reset, in_ready, done, word_count);
        end
        checks++;
        if (wr_q.size() != 7) begin
            errors++;
            $display("FAIL midreset_nwrites: got %0d expected 7", wr_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < 7; i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_write%0d: got %h expected %h", i, wr_q[i], exp_q[i]);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || cpu_reset !== 1'b1 || wr_q.size() != 7) begin
            errors++;
            $display("FAIL midreset_idle: got rdy=%b rst=%b writes=%0d expected 0 1 7",
                     in_ready, cpu_reset, wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_halt_load();
        test_back_to_back();
        test_random_load(1'b0);
        test_random_load(1'b1);
        test_full_load();
        test_restart();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
